// File: rtl/gpu_mem_pkg.sv
// Shared definitions for the GPU memory path: port FSM encoding, bus widths
// and the SDRAM window offset applied by the top level.
package gpu_mem_pkg;

  localparam int GPU_WORD_WIDTH          = 32;
  localparam int GPU_SDRAM_ADDRESS_WIDTH = 24;
  localparam int GPU_TIMEOUT_CYCLES      = 1024;

  localparam logic [29:0] SDRAM_BASE_OFFSET = 30'h3E000000;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_REQUEST   = 3'd1;
  localparam logic [2:0] ST_ISSUE     = 3'd2;
  localparam logic [2:0] ST_WAIT_DATA = 3'd3;
  localparam logic [2:0] ST_RELEASE   = 3'd4;

  typedef enum logic [2:0] {
    PORT_IDLE      = ST_IDLE,
    PORT_REQUEST   = ST_REQUEST,
    PORT_ISSUE     = ST_ISSUE,
    PORT_WAIT_DATA = ST_WAIT_DATA,
    PORT_RELEASE   = ST_RELEASE
  } mem_port_state_t;

endpackage

// File: rtl/gpu_sdram_port_if.sv
// Core, arbiter and Avalon SDRAM signals of one per-core memory port.
// The master side is the port itself; the slave side is core + arbiter + bus.
interface gpu_sdram_port_if
  import gpu_mem_pkg::*;
#(
  parameter int WORD_WIDTH          = GPU_WORD_WIDTH,
  parameter int SDRAM_ADDRESS_WIDTH = GPU_SDRAM_ADDRESS_WIDTH
);
  logic [SDRAM_ADDRESS_WIDTH-1:0] core_address;
  logic                           core_read;
  logic                           core_write;
  logic [WORD_WIDTH-1:0]          core_writedata;
  logic [WORD_WIDTH-1:0]          core_readdata;
  logic                           core_busy;
  logic                           core_done;
  logic                           core_error;

  logic                           mem_request;
  logic                           mem_authorized;

  logic [SDRAM_ADDRESS_WIDTH-1:0] sdram_address;
  logic                           sdram_read;
  logic                           sdram_write;
  logic [WORD_WIDTH-1:0]          sdram_writedata;
  logic                           sdram_waitrequest;
  logic [WORD_WIDTH-1:0]          sdram_readdata;
  logic                           sdram_readdatavalid;

  modport master (
    input  core_address, core_read, core_write, core_writedata,
    input  mem_authorized,
    input  sdram_waitrequest, sdram_readdata, sdram_readdatavalid,
    output core_readdata, core_busy, core_done, core_error,
    output mem_request,
    output sdram_address, sdram_read, sdram_write, sdram_writedata
  );

  modport slave (
    output core_address, core_read, core_write, core_writedata,
    output mem_authorized,
    output sdram_waitrequest, sdram_readdata, sdram_readdatavalid,
    input  core_readdata, core_busy, core_done, core_error,
    input  mem_request,
    input  sdram_address, sdram_read, sdram_write, sdram_writedata
  );

endinterface

// File: rtl/gpu_sdram_port.sv
// Per-core SDRAM port: takes one word access from the core, wins the shared
// Avalon bus from the arbiter, runs the transfer and releases the bus again.
module gpu_sdram_port
  import gpu_mem_pkg::*;
#(
  parameter int WORD_WIDTH          = GPU_WORD_WIDTH,
  parameter int SDRAM_ADDRESS_WIDTH = GPU_SDRAM_ADDRESS_WIDTH,
  parameter int TIMEOUT_CYCLES      = GPU_TIMEOUT_CYCLES
) (
  input  logic              clock,
  input  logic              reset_n,
  gpu_sdram_port_if.master  bus
);

  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [SDRAM_ADDRESS_WIDTH-1:0] ADDR_MASK =
    {{(SDRAM_ADDRESS_WIDTH-2){1'b1}}, 2'b00};

  logic [2:0]                     state_r, state_s;
  logic [SDRAM_ADDRESS_WIDTH-1:0] addr_r, addr_s;
  logic [WORD_WIDTH-1:0]          wdata_r, wdata_s;
  logic                           op_read_r, op_read_s;
  logic [CNT_WIDTH-1:0]           cnt_r, cnt_s;
  logic [WORD_WIDTH-1:0]          readdata_r, readdata_s;
  logic                           busy_r, busy_s;
  logic                           done_r, done_s;
  logic                           error_r, error_s;
  logic                           request_r, request_s;
  logic [SDRAM_ADDRESS_WIDTH-1:0] sdram_address_r, sdram_address_s;
  logic                           sdram_read_r, sdram_read_s;
  logic                           sdram_write_r, sdram_write_s;
  logic [WORD_WIDTH-1:0]          sdram_writedata_r, sdram_writedata_s;
  logic                           issue_s;

  // Next-state and next-output logic for the bus-ownership FSM.
  always_comb begin
    state_s    = state_r;
    addr_s     = addr_r;
    wdata_s    = wdata_r;
    op_read_s  = op_read_r;
    cnt_s      = cnt_r;
    readdata_s = readdata_r;
    request_s  = request_r;
    done_s     = 1'b0;
    error_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.core_read || bus.core_write) begin
          // A simultaneous read and write resolves to the read.
          addr_s    = bus.core_address & ADDR_MASK;
          wdata_s   = bus.core_writedata;
          op_read_s = bus.core_read;
          request_s = 1'b1;
          state_s   = ST_REQUEST;
        end else begin
          request_s = 1'b0;
        end
      end
      ST_REQUEST: begin
        if (bus.mem_authorized) begin
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_REQUEST;
        end
      end
      ST_ISSUE: begin
        if (bus.sdram_waitrequest) begin
          state_s = ST_ISSUE;
        end else if (op_read_r) begin
          cnt_s   = {CNT_WIDTH{1'b0}};
          state_s = ST_WAIT_DATA;
        end else begin
          done_s    = 1'b1;
          request_s = 1'b0;
          state_s   = ST_RELEASE;
        end
      end
      ST_WAIT_DATA: begin
        if (bus.sdram_readdatavalid) begin
          readdata_s = bus.sdram_readdata;
          done_s     = 1'b1;
          request_s  = 1'b0;
          state_s    = ST_RELEASE;
        end else if (cnt_r == CNT_LAST) begin
          done_s    = 1'b1;
          error_s   = 1'b1;
          request_s = 1'b0;
          state_s   = ST_RELEASE;
        end else begin
          cnt_s = cnt_r + CNT_WIDTH'(1);
        end
      end
      ST_RELEASE: begin
        // Hold off until the grant is gone so a stale grant never re-issues.
        if (bus.mem_authorized) begin
          state_s = ST_RELEASE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        request_s = 1'b0;
        state_s   = ST_IDLE;
      end
    endcase

    // Bus outputs are non-zero only while issuing, so all ports can be ORed.
    issue_s           = (state_s == ST_ISSUE);
    busy_s            = (state_s != ST_IDLE);
    sdram_address_s   = issue_s ? addr_s : {SDRAM_ADDRESS_WIDTH{1'b0}};
    sdram_read_s      = issue_s & op_read_s;
    sdram_write_s     = issue_s & ~op_read_s;
    sdram_writedata_s = (issue_s && !op_read_s) ? wdata_s : {WORD_WIDTH{1'b0}};
  end

  // State, latched command and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r           <= ST_IDLE;
      addr_r            <= {SDRAM_ADDRESS_WIDTH{1'b0}};
      wdata_r           <= {WORD_WIDTH{1'b0}};
      op_read_r         <= 1'b0;
      cnt_r             <= {CNT_WIDTH{1'b0}};
      readdata_r        <= {WORD_WIDTH{1'b0}};
      busy_r            <= 1'b0;
      done_r            <= 1'b0;
      error_r           <= 1'b0;
      request_r         <= 1'b0;
      sdram_address_r   <= {SDRAM_ADDRESS_WIDTH{1'b0}};
      sdram_read_r      <= 1'b0;
      sdram_write_r     <= 1'b0;
      sdram_writedata_r <= {WORD_WIDTH{1'b0}};
    end else begin
      state_r           <= state_s;
      addr_r            <= addr_s;
      wdata_r           <= wdata_s;
      op_read_r         <= op_read_s;
      cnt_r             <= cnt_s;
      readdata_r        <= readdata_s;
      busy_r            <= busy_s;
      done_r            <= done_s;
      error_r           <= error_s;
      request_r         <= request_s;
      sdram_address_r   <= sdram_address_s;
      sdram_read_r      <= sdram_read_s;
      sdram_write_r     <= sdram_write_s;
      sdram_writedata_r <= sdram_writedata_s;
    end
  end

  assign bus.core_readdata   = readdata_r;
  assign bus.core_busy       = busy_r;
  assign bus.core_done       = done_r;
  assign bus.core_error      = error_r;
  assign bus.mem_request     = request_r;
  assign bus.sdram_address   = sdram_address_r;
  assign bus.sdram_read      = sdram_read_r;
  assign bus.sdram_write     = sdram_write_r;
  assign bus.sdram_writedata = sdram_writedata_r;

endmodule
